lfsr_crc_frame: RTL and testbench



---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr.sv | 60 ++++++
 rtl/lfsr_crc_frame.sv | 107 ++++++++++
 tb/tb_lfsr_crc_frame.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the framed CRC engine: FSM encoding, keep-mask
// decoding and the Ethernet CRC-32 residue constant.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BODY,
    HOLD
  } frame_state_t;

  localparam logic [31:0] ETH_RESIDUE = 32'h2144df1c;

  // Length of the run of set bits starting at lane 0; 0 when lane 0 is clear.
  function automatic int keep_lanes(input logic [63:0] keep, input int width);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if (i >= width || !keep[i]) break;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/lfsr.sv
// Combinational LFSR/CRC next-state: advances state_in by every bit of data_in,
// lane 0 first, in either Galois or Fibonacci form.
module lfsr #(
  parameter int                    LFSR_WIDTH  = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 32'h04c11db7,
  parameter string                 LFSR_CONFIG = "GALOIS",
  parameter int                    REVERSE     = 1,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  localparam int IN_W = LFSR_WIDTH + DATA_WIDTH;

  function automatic logic [LFSR_WIDTH-1:0] step(input logic [LFSR_WIDTH-1:0] st_in,
                                                 input logic [DATA_WIDTH-1:0] d);
    logic [LFSR_WIDTH-1:0] st;
    logic b, fb;
    st = st_in;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b = (REVERSE != 0) ? d[i] : d[(i / 8) * 8 + 7 - (i % 8)];
      if (LFSR_CONFIG == "FIBONACCI") begin
        fb = b ^ st[LFSR_WIDTH-1] ^ (^(st[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
        st = {st[LFSR_WIDTH-2:0], fb};
      end else begin
        fb = b ^ st[LFSR_WIDTH-1];
        st = {st[LFSR_WIDTH-2:0], 1'b0} ^ (fb ? LFSR_POLY : '0);
      end
    end
    return st;
  endfunction

  // The update is linear, so each output bit is the parity of a fixed input mask.
  function automatic logic [LFSR_WIDTH-1:0][IN_W-1:0] build_masks();
    logic [IN_W-1:0]                  v;
    logic [LFSR_WIDTH-1:0]            o;
    logic [LFSR_WIDTH-1:0][IN_W-1:0]  m;
    m = '0;
    for (int j = 0; j < IN_W; j++) begin
      v    = '0;
      v[j] = 1'b1;
      o    = step(v[LFSR_WIDTH-1:0], v[IN_W-1:LFSR_WIDTH]);
      for (int i = 0; i < LFSR_WIDTH; i++) m[i][j] = o[i];
    end
    return m;
  endfunction

  if (STYLE == "LOOP") begin : g_loop
    assign state_out = step(state_in, data_in);
  end else begin : g_reduction
    localparam logic [LFSR_WIDTH-1:0][IN_W-1:0] MASKS = build_masks();
    for (genvar i = 0; i < LFSR_WIDTH; i++) begin : g_bit
      assign state_out[i] = ^({data_in, state_in} & MASKS[i]);
    end
  end

endmodule

// File: rtl/lfsr_crc_frame.sv
// Framed multi-lane CRC generator/checker: one result per frame on a
// valid/ready stream, with partial last beats selected by a byte keep mask.
module lfsr_crc_frame
  import lfsr_pkg::*;
#(
  parameter int                    LFSR_WIDTH    = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 32'h04c11db7,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT     = '1,
  parameter string                 LFSR_CONFIG   = "GALOIS",
  parameter int                    REVERSE       = 1,
  parameter int                    INVERT        = 1,
  parameter int                    KEEP_WIDTH    = 8,
  parameter logic [LFSR_WIDTH-1:0] CHECK_RESIDUE = ETH_RESIDUE,
  parameter string                 STYLE         = "AUTO"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [8*KEEP_WIDTH-1:0] s_data,
  input  logic [KEEP_WIDTH-1:0]   s_keep,
  input  logic                    s_last,
  input  logic                    s_valid,
  output logic                    s_ready,
  output logic [LFSR_WIDTH-1:0]   m_crc,
  output logic                    m_crc_ok,
  output logic                    m_keep_err,
  output logic                    m_valid,
  input  logic                    m_ready
);

  localparam int CNT_W = $clog2(KEEP_WIDTH + 1);

  frame_state_t          state, state_next;
  logic [LFSR_WIDTH-1:0] crc_q, crc_in, crc_next, crc_fmt;
  logic [LFSR_WIDTH-1:0] lane_out [KEEP_WIDTH];
  logic [CNT_W-1:0]      lane_cnt;
  logic [KEEP_WIDTH-1:0] lane_mask;
  logic                  accept, frame_start, beat_err, err_q, frame_err;

  assign m_valid     = (state == HOLD);
  assign s_ready     = rst_n && !(m_valid && !m_ready);
  assign accept      = s_valid && s_ready;
  // A frame opens on any beat accepted outside BODY, so back-to-back frames
  // seed from LFSR_INIT without an idle cycle.
  assign frame_start = (state != BODY);
  assign crc_in      = frame_start ? LFSR_INIT : crc_q;

  for (genvar i = 0; i < KEEP_WIDTH; i++) begin : g_lane
    lfsr #(
      .LFSR_WIDTH (LFSR_WIDTH),
      .LFSR_POLY  (LFSR_POLY),
      .LFSR_CONFIG(LFSR_CONFIG),
      .REVERSE    (REVERSE),
      .DATA_WIDTH (8 * (i + 1)),
      .STYLE      (STYLE)
    ) u_lfsr (
      .data_in  (s_data[8*(i+1)-1:0]),
      .state_in (crc_in),
      .state_out(lane_out[i])
    );
  end

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    lane_cnt  = CNT_W'(keep_lanes(64'(s_keep), KEEP_WIDTH));
    lane_mask = '0;
    crc_next  = crc_in;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      lane_mask[i] = (i < int'(lane_cnt));
      if (int'(lane_cnt) == i + 1) crc_next = lane_out[i];
    end
    beat_err  = s_last ? (lane_cnt == '0 || s_keep != lane_mask) : (s_keep != '1);
    frame_err = (frame_start ? 1'b0 : err_q) | beat_err;
    for (int i = 0; i < LFSR_WIDTH; i++)
      crc_fmt[i] = (REVERSE != 0) ? crc_next[LFSR_WIDTH-1-i] : crc_next[i];
    if (INVERT != 0) crc_fmt = ~crc_fmt;
  end

  always_comb begin
    state_next = state;
    if (accept)                       state_next = s_last ? HOLD : BODY;
    else if (state == HOLD && m_ready) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      crc_q      <= LFSR_INIT;
      err_q      <= 1'b0;
      m_crc      <= '0;
      m_crc_ok   <= 1'b0;
      m_keep_err <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        crc_q <= crc_next;
        err_q <= frame_err;
        if (s_last) begin
          m_crc      <= crc_fmt;
          m_crc_ok   <= (crc_fmt == CHECK_RESIDUE);
          m_keep_err <= frame_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_lfsr_crc_frame.sv
// Directed bench for lfsr_crc_frame: table of frames plus hand-written
// back-to-back, backpressure and mid-frame reset sequences.
module tb_lfsr_crc_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] s_data;
  logic [7:0]  s_keep;
  logic        s_last, s_valid, s_ready;
  logic [31:0] m_crc;
  logic        m_crc_ok, m_keep_err, m_valid, m_ready;

  lfsr_crc_frame dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_keep    (s_keep),
    .s_last    (s_last),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .m_crc     (m_crc),
    .m_crc_ok  (m_crc_ok),
    .m_keep_err(m_keep_err),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reflected bit-serial CRC-32 over n0 bytes of d0 then n1 bytes of d1.
  function automatic logic [31:0] crc_ref(input logic [63:0] d0, input int n0,
                                          input logic [63:0] d1, input int n1);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hffffffff;
    for (int i = 0; i < n0 + n1; i++) begin
      b = (i < n0) ? d0[8*i +: 8] : d1[8*(i-n0) +: 8];
      c ^= {24'h0, b};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    return ~c;
  endfunction

  typedef struct {
    logic [63:0] d0;
    logic [7:0]  k0;
    bit          two;
    logic [63:0] d1;
    logic [7:0]  k1;
    logic [31:0] crc;
    bit          ok;
    bit          err;
  } vec_t;

  localparam logic [63:0] D_12345678 = 64'h3837363534333231;
  localparam logic [63:0] D_1234     = 64'ha5a5a5a534333231;
  localparam logic [63:0] D_5678     = 64'ha5a5a5a538373635;

  vec_t vecs [7];

  // Drive one beat at a negedge; returns at the negedge after acceptance.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic last);
    int n;
    s_data  = d;
    s_keep  = k;
    s_last  = last;
    s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 64'hdeadbeefdeadbeef;
  endtask

  task automatic check_result(input string name, input logic [31:0] crc, input bit ok,
                              input bit err);
    check({name, "_valid"}, 32'(m_valid), 32'd1);
    check({name, "_crc"}, m_crc, crc);
    check({name, "_ok"}, 32'(m_crc_ok), 32'(ok));
    check({name, "_keep_err"}, 32'(m_keep_err), 32'(err));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] c1234, c5678, ex;

    c1234 = crc_ref(D_1234, 4, 64'h0, 0);
    c5678 = crc_ref(D_5678, 4, 64'h0, 0);

    vecs[0] = '{D_12345678, 8'hff, 1'b1, 64'ha5a5a5a5a5a5a539, 8'h01, 32'hcbf43926, 1'b0, 1'b0};
    vecs[1] = '{D_12345678, 8'hff, 1'b1, 64'ha5a5a5cbf4392639, 8'h1f, 32'h2144df1c, 1'b1, 1'b0};
    vecs[2] = '{D_1234, 8'h0f, 1'b0, 64'h0, 8'h00, c1234, 1'b0, 1'b0};
    vecs[3] = '{64'ha5a5a5a5a5a54241, 8'h05, 1'b0, 64'h0, 8'h00,
                crc_ref(64'h41, 1, 64'h0, 0), 1'b0, 1'b1};
    vecs[4] = '{D_5678, 8'h0f, 1'b0, 64'h0, 8'h00, c5678, 1'b0, 1'b0};
    vecs[5] = '{64'h0123456789abcdef, 8'hff, 1'b0, 64'h0, 8'h00,
                crc_ref(64'h0123456789abcdef, 8, 64'h0, 0), 1'b0, 1'b0};
    vecs[6] = '{D_12345678, 8'hff, 1'b1, 64'h1122334455667788, 8'h00,
                crc_ref(D_12345678, 8, 64'h0, 0), 1'b0, 1'b1};

    rst_n   = 1'b0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_crc", m_crc, 32'd0);
    check("rst_m_crc_ok", 32'(m_crc_ok), 32'd0);
    check("rst_m_keep_err", 32'(m_keep_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_s_ready", 32'(s_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].two) begin
        send_beat(vecs[i].d0, vecs[i].k0, 1'b0);
        send_beat(vecs[i].d1, vecs[i].k1, 1'b1);
      end else begin
        send_beat(vecs[i].d0, vecs[i].k0, 1'b1);
      end
      check_result($sformatf("vec%0d", i), vecs[i].crc, vecs[i].ok, vecs[i].err);
      @(negedge clk);
      check($sformatf("vec%0d_consumed", i), 32'(m_valid), 32'd0);
    end

    // Back-to-back single-beat frames on consecutive cycles
    s_data = D_1234; s_keep = 8'h0f; s_last = 1'b1; s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_result("b2b_first", c1234, 1'b0, 1'b0);
    check("b2b_s_ready", 32'(s_ready), 32'd1);
    s_data = D_5678;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check_result("b2b_second", c5678, 1'b0, 1'b0);
    @(negedge clk);
    check("b2b_drained", 32'(m_valid), 32'd0);

    // Backpressure: result held while a last beat waits
    m_ready = 1'b0;
    send_beat(D_1234, 8'h0f, 1'b1);
    s_data = D_5678; s_keep = 8'h0f; s_last = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d_valid", i), 32'(m_valid), 32'd1);
      check($sformatf("bp%0d_crc", i), m_crc, c1234);
      check($sformatf("bp%0d_s_ready", i), 32'(s_ready), 32'd0);
      @(negedge clk);
    end
    m_ready = 1'b1;
    #1;
    check("bp_release_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    check_result("bp_next", c5678, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_drained", 32'(m_valid), 32'd0);

    // Mid-frame reset discards the open frame
    send_beat(D_12345678, 8'hff, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_no_spurious", 32'(m_valid), 32'd0);
    send_beat(D_12345678, 8'hff, 1'b0);
    send_beat(64'ha5a5a5a5a5a5a539, 8'h01, 1'b1);
    ex = 32'hcbf43926;
    check_result("midrst_frame", ex, 1'b0, 1'b0);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
